// File: rtl/bkram_pkg.sv
// Shared types and constants for the backup-RAM sector sequencer.
package bkram_pkg;

    localparam int BK_SECTORS_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_FMT  = 2'd2
    } bk_state_e;

    // Save-image header laid down by a format request, word 0 first.
    localparam logic [15:0] BK_HEADER [4] = '{16'h5548, 16'h4D42, 16'h8800, 16'h8010};

endpackage

// File: rtl/bkram_sync_ctrl_edge.sv
// Registered-compare edge detector; FALLING selects which transition pulses o_edge.
module edge_rise #(
    parameter bit FALLING = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sig,
    output logic o_edge
);

    logic r_prev;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_prev <= 1'b0;
        else       r_prev <= i_sig;
    end

    assign o_edge = FALLING ? (r_prev & ~i_sig) : (~r_prev & i_sig);

endmodule

// File: rtl/bkram_sync_ctrl.sv
// Backup-RAM load/save/format sequencer driving the HPS SD interface and RAM port B.
// Optional BKRAM_AUTOSAVE_EN: save on OSD close while dirty.
module bkram_sync_ctrl
    import bkram_pkg::*;
#(
    parameter int SECTORS = BK_SECTORS_DEFAULT,
    parameter int LBA_W   = $clog2(SECTORS)
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic               bk_ena,
    input  logic               load_req,
    input  logic               save_req,
    input  logic               format_req,
    input  logic               dl_done,
    input  logic               img_size_nz,
    output logic [31:0]        sd_lba,
    output logic               sd_rd,
    output logic               sd_wr,
    input  logic               sd_ack,
    input  logic [7:0]         sd_buff_addr,
    input  logic [15:0]        sd_buff_dout,
    input  logic               sd_buff_wr,
    input  logic               core_bram_we,
    input  logic               osd_status,
    output logic [LBA_W+7:0]   bram_b_addr,
    output logic [15:0]        bram_b_data,
    output logic               bram_b_we,
    output logic               busy,
    output logic               loading,
    output logic               dirty,
    output logic [1:0]         o_dbg_state
);

    bk_state_e        r_state, w_state_nxt;
    logic [LBA_W-1:0] r_lba, w_lba_nxt;
    logic [1:0]       r_cnt, w_cnt_nxt;
    logic             r_rd, w_rd_nxt;
    logic             r_wr, w_wr_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_loading, w_loading_nxt;
    logic             r_dirty, w_dirty_nxt;
    logic             w_dirty_clr, w_fmt_done;

    logic w_load_rise, w_save_rise, w_fmt_rise, w_ack_rise, w_ack_fall, w_osd_fall;

    edge_rise #(.FALLING(1'b0)) u_load_edge (.i_clk(clk_sys), .i_rst(reset), .i_sig(load_req),   .o_edge(w_load_rise));
    edge_rise #(.FALLING(1'b0)) u_save_edge (.i_clk(clk_sys), .i_rst(reset), .i_sig(save_req),   .o_edge(w_save_rise));
    edge_rise #(.FALLING(1'b0)) u_fmt_edge  (.i_clk(clk_sys), .i_rst(reset), .i_sig(format_req), .o_edge(w_fmt_rise));
    edge_rise #(.FALLING(1'b0)) u_ack_rise  (.i_clk(clk_sys), .i_rst(reset), .i_sig(sd_ack),     .o_edge(w_ack_rise));
    edge_rise #(.FALLING(1'b1)) u_ack_fall  (.i_clk(clk_sys), .i_rst(reset), .i_sig(sd_ack),     .o_edge(w_ack_fall));

`ifdef BKRAM_AUTOSAVE_EN
    edge_rise #(.FALLING(1'b1)) u_osd_fall  (.i_clk(clk_sys), .i_rst(reset), .i_sig(osd_status), .o_edge(w_osd_fall));
`else
    logic w_unused_osd;
    assign w_unused_osd = osd_status;
    assign w_osd_fall   = 1'b0;
`endif

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_lba     <= '0;
            r_cnt     <= 2'd0;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_busy    <= 1'b0;
            r_loading <= 1'b0;
            r_dirty   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_lba     <= w_lba_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rd      <= w_rd_nxt;
            r_wr      <= w_wr_nxt;
            r_busy    <= w_busy_nxt;
            r_loading <= w_loading_nxt;
            r_dirty   <= w_dirty_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_lba_nxt     = r_lba;
        w_cnt_nxt     = r_cnt;
        w_rd_nxt      = r_rd;
        w_wr_nxt      = r_wr;
        w_busy_nxt    = r_busy;
        w_loading_nxt = r_loading;
        w_dirty_nxt   = r_dirty;
        w_dirty_clr   = 1'b0;
        w_fmt_done    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Edges seen outside IDLE are simply lost; nothing is queued.
                if (w_fmt_rise) begin
                    w_cnt_nxt   = 2'd0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = ST_FMT;
                end else if ((dl_done && bk_ena && img_size_nz) || (w_load_rise && bk_ena)) begin
                    w_lba_nxt     = '0;
                    w_loading_nxt = 1'b1;
                    w_busy_nxt    = 1'b1;
                    w_rd_nxt      = 1'b1;
                    w_state_nxt   = ST_XFER;
                end else if ((w_save_rise || w_osd_fall && r_dirty) && bk_ena) begin
                    w_lba_nxt     = '0;
                    w_loading_nxt = 1'b0;
                    w_busy_nxt    = 1'b1;
                    w_wr_nxt      = 1'b1;
                    w_state_nxt   = ST_XFER;
                end
            end
            ST_XFER: begin
                if (w_ack_rise) begin
                    w_rd_nxt = 1'b0;
                    w_wr_nxt = 1'b0;
                end
                if (w_ack_fall) begin
                    if (r_lba == LBA_W'(SECTORS - 1)) begin
                        w_busy_nxt    = 1'b0;
                        w_loading_nxt = 1'b0;
                        w_dirty_clr   = 1'b1;
                        w_state_nxt   = ST_IDLE;
                    end else begin
                        w_lba_nxt = r_lba + LBA_W'(1);
                        w_rd_nxt  = r_loading;
                        w_wr_nxt  = ~r_loading;
                    end
                end
            end
            ST_FMT: begin
                w_cnt_nxt = r_cnt + 2'd1;
                if (r_cnt == 2'd3) begin
                    w_busy_nxt  = 1'b0;
                    w_fmt_done  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // A core write landing on the completion cycle keeps the image dirty.
        if (w_dirty_clr) w_dirty_nxt = 1'b0;
        if (w_fmt_done || (core_bram_we && !r_loading)) w_dirty_nxt = 1'b1;
    end

    logic w_in_fmt;
    assign w_in_fmt = (r_state == ST_FMT);

    assign bram_b_addr = w_in_fmt ? {{(LBA_W + 6){1'b0}}, r_cnt} : {r_lba, sd_buff_addr};
    assign bram_b_data = w_in_fmt ? BK_HEADER[r_cnt] : sd_buff_dout;
    assign bram_b_we   = w_in_fmt | (sd_buff_wr & sd_ack & r_loading);

    assign sd_lba      = {{(32 - LBA_W){1'b0}}, r_lba};
    assign sd_rd       = r_rd;
    assign sd_wr       = r_wr;
    assign busy        = r_busy;
    assign loading     = r_loading;
    assign dirty       = r_dirty;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bkram_sync_ctrl.sv
// Self-checking bench for bkram_sync_ctrl with an HPS sector model and a port-B write scoreboard.
module tb_bkram_sync_ctrl;

  localparam int SECTORS = 16;
  localparam int LBA_W   = 4;
  localparam int AW      = LBA_W + 8;
  localparam int EW      = AW + 16;

  logic clk_sys = 1'b0;
  logic reset;
  logic bk_ena, load_req, save_req, format_req, dl_done, img_size_nz;
  logic [31:0] sd_lba;
  logic sd_rd, sd_wr, sd_ack;
  logic [7:0] sd_buff_addr;
  logic [15:0] sd_buff_dout;
  logic sd_buff_wr, core_bram_we, osd_status;
  logic [AW-1:0] bram_b_addr;
  logic [15:0] bram_b_data;
  logic bram_b_we, busy, loading, dirty;
  logic [1:0] dbg_state;

  logic [EW-1:0] exp_q[$];
  logic [15:0] hdr [4] = '{16'h5548, 16'h4D42, 16'h8800, 16'h8010};
  int n_vec = 0;
  int n_err = 0;
  int we_cnt = 0;

  bkram_sync_ctrl #(.SECTORS(SECTORS), .LBA_W(LBA_W)) dut (
    .clk_sys(clk_sys), .reset(reset), .bk_ena(bk_ena), .load_req(load_req),
    .save_req(save_req), .format_req(format_req), .dl_done(dl_done),
    .img_size_nz(img_size_nz), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_wr(sd_buff_wr), .core_bram_we(core_bram_we), .osd_status(osd_status),
    .bram_b_addr(bram_b_addr), .bram_b_data(bram_b_data), .bram_b_we(bram_b_we),
    .busy(busy), .loading(loading), .dirty(dirty), .o_dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk_sys = ~clk_sys;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  // port-B write scoreboard
  always @(negedge clk_sys) begin
    if (!reset && bram_b_we) begin
      we_cnt++;
      if (exp_q.size() == 0) check_val("bram_we_spurious", 32'(bram_b_we), 32'd0);
      else check_val("bram_wr", 32'({bram_b_addr, bram_b_data}), 32'(exp_q.pop_front()));
    end
  end

  // drivers
  task automatic pulse(input int which);
    @(posedge clk_sys); #1;
    case (which)
      0: load_req = 1'b1;
      1: save_req = 1'b1;
      2: format_req = 1'b1;
      default: core_bram_we = 1'b1;
    endcase
    @(posedge clk_sys); #1;
    load_req = 1'b0; save_req = 1'b0; format_req = 1'b0; core_bram_we = 1'b0;
  endtask

  task automatic wait_req();
    int i = 0;
    while (i < 20 && !(sd_rd || sd_wr)) begin
      @(negedge clk_sys);
      i++;
    end
    check_val("req_seen", 32'(sd_rd | sd_wr), 32'd1);
  endtask

  task automatic serve_sector(input bit is_load, input int lba);
    @(posedge clk_sys); #1 sd_ack = 1'b1;
    for (int w = 0; w < 256; w++) begin
      @(posedge clk_sys); #1;
      sd_buff_wr = 1'b1;
      sd_buff_addr = 8'(w);
      sd_buff_dout = 16'($urandom_range(0, 65535));
      if (is_load) exp_q.push_back({LBA_W'(lba), 8'(w), sd_buff_dout});
      if (w == 0) begin
        @(negedge clk_sys);
        check_val("req_drop", 32'(sd_rd | sd_wr), 32'd0);
      end
    end
    @(posedge clk_sys); #1;
    sd_buff_wr = 1'b0;
    sd_ack = 1'b0;
  endtask

  task automatic run_xfer(input bit is_load, input int n_sec);
    for (int s = 0; s < n_sec; s++) begin
      @(negedge clk_sys);
      wait_req();
      if (!(sd_rd || sd_wr)) return;
      check_val("xfer_lba", sd_lba, 32'(s));
      check_val("xfer_rd", 32'(sd_rd), 32'(is_load));
      check_val("xfer_wr", 32'(sd_wr), 32'(!is_load));
      check_val("xfer_loading", 32'(loading), 32'(is_load));
      check_val("xfer_busy", 32'(busy), 32'd1);
      serve_sector(is_load, s);
    end
  endtask

  task automatic check_done(input string tag);
    @(posedge clk_sys);
    @(negedge clk_sys);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_loading"}, 32'(loading), 32'd0);
    check_val({tag, "_dirty"}, 32'(dirty), 32'd0);
    check_val({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  task automatic check_fmt(input string tag);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_sys);
      check_val({tag, "_we"}, 32'(bram_b_we), 32'd1);
      check_val({tag, "_addr"}, 32'(bram_b_addr), 32'(k));
      check_val({tag, "_data"}, 32'(bram_b_data), 32'(hdr[k]));
      check_val({tag, "_busy"}, 32'(busy), 32'd1);
    end
    @(negedge clk_sys);
    check_val({tag, "_busy_end"}, 32'(busy), 32'd0);
    check_val({tag, "_we_end"}, 32'(bram_b_we), 32'd0);
    check_val({tag, "_dirty"}, 32'(dirty), 32'd1);
  endtask

  task automatic watch_idle(input string tag, input int cycles);
    int hits = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_sys);
      if (sd_rd || sd_wr || busy) hits++;
    end
    check_val(tag, 32'(hits), 32'd0);
  endtask

  task automatic push_fmt();
    for (int k = 0; k < 4; k++) exp_q.push_back({AW'(k), hdr[k]});
  endtask

  initial begin
    int base;
    reset = 1'b1;
    bk_ena = 1'b0; load_req = 1'b0; save_req = 1'b0; format_req = 1'b0;
    dl_done = 1'b0; img_size_nz = 1'b0; sd_ack = 1'b0; sd_buff_addr = 8'd0;
    sd_buff_dout = 16'd0; sd_buff_wr = 1'b0; core_bram_we = 1'b0; osd_status = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1 reset = 1'b0;
    @(negedge clk_sys);
    check_val("rst_outputs", {sd_rd, sd_wr, busy, loading, dirty, bram_b_we}, 32'd0);
    check_val("rst_lba", sd_lba, 32'd0);
    check_val("rst_state", 32'(dbg_state), 32'd0);

    // load 16 sectors
    bk_ena = 1'b1; img_size_nz = 1'b1;
    pulse(3);
    @(negedge clk_sys);
    check_val("dirty_set", 32'(dirty), 32'd1);
    base = we_cnt;
    pulse(0);
    run_xfer(1'b1, SECTORS);
    check_done("load");
    check_val("load_we_count", 32'(we_cnt - base), 32'd4096);

    // save refused without a mounted image, then accepted
    bk_ena = 1'b0;
    pulse(1);
    watch_idle("save_noimg_idle", 10);
    bk_ena = 1'b1;
    pulse(3);
    @(negedge clk_sys);
    check_val("dirty_set2", 32'(dirty), 32'd1);
    base = we_cnt;
    pulse(1);
    run_xfer(1'b0, SECTORS);
    check_done("save");
    check_val("save_we_count", 32'(we_cnt - base), 32'd0);

    // format
    push_fmt();
    pulse(2);
    check_fmt("fmt");

    // dl_done + load + format together: format wins, the rest is dropped
    push_fmt();
    @(posedge clk_sys); #1;
    dl_done = 1'b1; load_req = 1'b1; format_req = 1'b1;
    @(posedge clk_sys); #1;
    dl_done = 1'b0; load_req = 1'b0; format_req = 1'b0;
    check_fmt("prio");
    watch_idle("prio_no_xfer", 30);

    // reset while lba 7 is requested
    pulse(0);
    run_xfer(1'b1, 7);
    @(negedge clk_sys);
    wait_req();
    check_val("rst_mid_lba", sd_lba, 32'd7);
    check_val("rst_mid_rd", 32'(sd_rd), 32'd1);
    @(posedge clk_sys); #1 reset = 1'b1;
    #1 check_val("rst_async_rd", 32'(sd_rd), 32'd0);
    @(negedge clk_sys);
    check_val("rst_mid_outputs", {sd_rd, sd_wr, busy, loading, dirty, bram_b_we}, 32'd0);
    check_val("rst_mid_lba0", sd_lba, 32'd0);
    @(posedge clk_sys); #1 reset = 1'b0;
    pulse(0);
    run_xfer(1'b1, SECTORS);
    check_done("reload");

    // OSD close with a dirty image
    pulse(3);
    @(posedge clk_sys); #1 osd_status = 1'b1;
    @(posedge clk_sys); #1 osd_status = 1'b0;
`ifdef BKRAM_AUTOSAVE_EN
    run_xfer(1'b0, SECTORS);
    check_done("autosave");
`else
    watch_idle("no_autosave", 30);
    check_val("no_autosave_dirty", 32'(dirty), 32'd1);
`endif

    repeat (3) @(negedge clk_sys);
    check_val("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
